// File: rtl/acc_core.sv
// acc_core: parametrised multi-cycle accumulator core.
//
// Runs a fetch/execute loop against an external synchronous read-only program memory.
// Each instruction takes two cycles. FETCH drives the address. EXEC consumes the returned
// word and commits the result at the end of the cycle.
// Instruction word layout (MSB to LSB): {reg_sel[REG_AW], opcode[4], imm[DATA_W]}.
//
// Build option: define ACC_CORE_BRANCH_EN to implement JMP/JZ/JC. When it is undefined,
// those opcodes behave as NOP.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   start      begin execution at address 0 (honoured only in IDLE/HALT)
//   imem_addr  program memory address (equals pc)
//   imem_data  instruction word, valid the cycle after imem_addr
//   acu_dbg    accumulator value
//   pc_dbg     program counter
//   flag_z     zero flag
//   flag_cy    carry/borrow flag
//   retire     high during each EXEC cycle
//   halted     high in HALT state
module acc_core #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned PC_W     = 5,
    localparam int unsigned REG_AW  = $clog2(NUM_REGS),
    localparam int unsigned IW      = REG_AW + 4 + DATA_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [IW-1:0]     imem_data,
    output logic [DATA_W-1:0] acu_dbg,
    output logic [PC_W-1:0]   pc_dbg,
    output logic              flag_z,
    output logic              flag_cy,
    output logic              retire,
    output logic              halted
);

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

    typedef enum logic [3:0] {
        OpNop = 4'h0, OpLdi = 4'h1, OpLdr = 4'h2, OpStr = 4'h3,
        OpAdd = 4'h4, OpSub = 4'h5, OpAnd = 4'h6, OpOr  = 4'h7,
        OpXor = 4'h8, OpNot = 4'h9, OpShl = 4'hA, OpShr = 4'hB,
        OpJmp = 4'hC, OpJz  = 4'hD, OpJc  = 4'hE, OpHlt = 4'hF
    } op_e;

    state_e              state_q;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [DATA_W-1:0]   acu_q, acu_d;
    logic                z_q, z_d;
    logic                cy_q, cy_d;
    logic                retire_q, halted_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    // Instruction fields
    logic [REG_AW-1:0]   reg_sel;
    op_e                 opc;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   reg_val;

    logic                acu_we, reg_we, br_taken, is_hlt;
    logic [DATA_W:0]     sum, diff;

    assign reg_sel = imem_data[IW-1 -: REG_AW];
    assign opc     = op_e'(imem_data[DATA_W+3:DATA_W]);
    assign imm     = imem_data[DATA_W-1:0];
    assign reg_val = regs_q[reg_sel];

    always_comb begin
        acu_d    = acu_q;
        z_d      = z_q;
        cy_d     = cy_q;
        acu_we   = 1'b0;
        reg_we   = 1'b0;
        br_taken = 1'b0;
        is_hlt   = 1'b0;
        sum      = {1'b0, acu_q} + {1'b0, reg_val};
        // The top bit of the widened difference is the borrow, i.e. acu < R
        diff     = {1'b0, acu_q} - {1'b0, reg_val};
        case (opc)
            OpLdi: begin acu_d = imm;              acu_we = 1'b1; end
            OpLdr: begin acu_d = reg_val;          acu_we = 1'b1; end
            OpStr: reg_we = 1'b1;
            OpAdd: begin {cy_d, acu_d} = sum;      acu_we = 1'b1; end
            OpSub: begin {cy_d, acu_d} = diff;     acu_we = 1'b1; end
            OpAnd: begin acu_d = acu_q & reg_val;  cy_d = 1'b0; acu_we = 1'b1; end
            OpOr:  begin acu_d = acu_q | reg_val;  cy_d = 1'b0; acu_we = 1'b1; end
            OpXor: begin acu_d = acu_q ^ reg_val;  cy_d = 1'b0; acu_we = 1'b1; end
            OpNot: begin acu_d = ~acu_q;           cy_d = 1'b0; acu_we = 1'b1; end
            OpShl: begin
                acu_d  = {acu_q[DATA_W-2:0], 1'b0};
                cy_d   = acu_q[DATA_W-1];
                acu_we = 1'b1;
            end
            OpShr: begin
                acu_d  = {1'b0, acu_q[DATA_W-1:1]};
                cy_d   = acu_q[0];
                acu_we = 1'b1;
            end
`ifdef ACC_CORE_BRANCH_EN
            OpJmp: br_taken = 1'b1;
            OpJz:  br_taken = z_q;
            OpJc:  br_taken = cy_q;
`endif
            OpHlt: is_hlt = 1'b1;
            default: ;
        endcase
        if (acu_we) begin
            z_d = (acu_d == '0);
        end
    end

    // Branch target is the low bits of imm, zero-extended when imm is narrower than pc
    assign pc_d = br_taken ? PC_W'(imm) : pc_q + PC_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            acu_q    <= '0;
            z_q      <= 1'b0;
            cy_q     <= 1'b0;
            retire_q <= 1'b0;
            halted_q <= 1'b0;
            regs_q   <= '{default: '0};
        end else begin
            unique case (state_q)
                StIdle, StHalt: begin
                    if (start) begin
                        state_q  <= StFetch;
                        pc_q     <= '0;
                        halted_q <= 1'b0;
                    end
                end
                StFetch: begin
                    state_q  <= StExec;
                    retire_q <= 1'b1;
                end
                StExec: begin
                    retire_q <= 1'b0;
                    acu_q    <= acu_d;
                    z_q      <= z_d;
                    cy_q     <= cy_d;
                    if (reg_we) begin
                        regs_q[reg_sel] <= acu_q;
                    end
                    // pc is left pointing at the HLT for debug visibility
                    if (is_hlt) begin
                        state_q  <= StHalt;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= StFetch;
                        pc_q    <= pc_d;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign pc_dbg    = pc_q;
    assign acu_dbg   = acu_q;
    assign flag_z    = z_q;
    assign flag_cy   = cy_q;
    assign retire    = retire_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_acc_core.sv
// Testbench for acc_core at default parameters: table-driven ALU vectors, hand sequences for
// reset, branch, wrap and restart, and random programs against a behavioural model.
module tb_acc_core;

    localparam int DW = 8;
    localparam int PW = 5;
    localparam int IW = 14;
    localparam int MEMSZ = 32;

    localparam logic [3:0] OP_NOP = 4'h0, OP_LDI = 4'h1, OP_LDR = 4'h2, OP_STR = 4'h3,
                           OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
                           OP_XOR = 4'h8, OP_NOT = 4'h9, OP_SHL = 4'hA, OP_SHR = 4'hB,
                           OP_JMP = 4'hC, OP_JZ  = 4'hD, OP_HLT = 4'hF;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          start = 1'b0;
    logic [PW-1:0] imem_addr;
    logic [IW-1:0] imem_data;
    logic [DW-1:0] acu_dbg;
    logic [PW-1:0] pc_dbg;
    logic          flag_z, flag_cy, retire, halted;

    acc_core dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .acu_dbg   (acu_dbg),
        .pc_dbg    (pc_dbg),
        .flag_z    (flag_z),
        .flag_cy   (flag_cy),
        .retire    (retire),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: word for the address seen at a rising edge appears after it
    logic [IW-1:0] mem [MEMSZ];
    always @(posedge clk) imem_data <= mem[imem_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] ins(input logic [3:0] op, input logic [1:0] rs,
                                          input logic [7:0] imm);
        return {rs, op, imm};
    endfunction

    // Behavioural reference model
    int m_acu, m_z, m_cy, m_pc, m_halted;
    int m_regs [4];

    task automatic model_reset();
        m_acu = 0; m_z = 0; m_cy = 0; m_pc = 0; m_halted = 0;
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
    endtask

    task automatic model_step();
        logic [IW-1:0] w;
        int op, rs, imm, a, r, res, npc;
        bit wr;
        w   = mem[m_pc];
        op  = int'(w[11:8]);
        rs  = int'(w[13:12]);
        imm = int'(w[7:0]);
        a   = m_acu;
        r   = m_regs[rs];
        res = 0;
        wr  = 1'b0;
        npc = (m_pc + 1) % MEMSZ;
        case (op)
            1:  begin res = imm; wr = 1; end
            2:  begin res = r; wr = 1; end
            3:  m_regs[rs] = a;
            4:  begin res = a + r; m_cy = (res > 255) ? 1 : 0; wr = 1; end
            5:  begin res = a - r; m_cy = (a < r) ? 1 : 0; if (res < 0) res += 256; wr = 1; end
            6:  begin res = a & r; m_cy = 0; wr = 1; end
            7:  begin res = a | r; m_cy = 0; wr = 1; end
            8:  begin res = a ^ r; m_cy = 0; wr = 1; end
            9:  begin res = 255 - a; m_cy = 0; wr = 1; end
            10: begin res = a * 2; m_cy = (a >= 128) ? 1 : 0; wr = 1; end
            11: begin res = a / 2; m_cy = a % 2; wr = 1; end
`ifdef ACC_CORE_BRANCH_EN
            12: npc = imm % MEMSZ;
            13: if (m_z != 0) npc = imm % MEMSZ;
            14: if (m_cy != 0) npc = imm % MEMSZ;
`endif
            15: begin m_halted = 1; npc = m_pc; end
            default: ;
        endcase
        if (wr) begin
            m_acu = res % 256;
            m_z   = (m_acu == 0) ? 1 : 0;
        end
        m_pc = npc;
    endtask

    // Leaves the bench at a falling edge with the core in IDLE
    task automatic do_reset();
        rstn = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic fill(input logic [IW-1:0] w);
        for (int k = 0; k < MEMSZ; k++) mem[k] = w;
    endtask

    // Start from IDLE/HALT and execute up to max_instr instructions, checking every retire.
    // Must be called at a falling edge with the core in IDLE or HALT.
    task automatic run(input int max_instr, input bit rand_start);
        start = 1'b1;
        m_pc = 0;
        m_halted = 0;
        @(negedge clk);
        start = 1'b0;
        chk("fetch_retire", 32'(retire), 0);
        chk("fetch_addr", 32'(imem_addr), 0);
        for (int i = 0; i < max_instr; i++) begin
            @(negedge clk);
            chk("exec_retire", 32'(retire), 1);
            if (rand_start) start = 1'($urandom);
            model_step();
            @(negedge clk);
            chk("post_retire", 32'(retire), 0);
            chk("acu", 32'(acu_dbg), m_acu);
            chk("flag_z", 32'(flag_z), m_z);
            chk("flag_cy", 32'(flag_cy), m_cy);
            chk("pc", 32'(pc_dbg), m_pc);
            chk("imem_addr", 32'(imem_addr), m_pc);
            chk("halted", 32'(halted), m_halted);
            if (m_halted != 0) begin
                start = 1'b0;
                break;
            end
            if (rand_start) start = 1'($urandom);
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] r;
        logic [7:0] e_acu;
        logic       e_z;
        logic       e_cy;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl [NV];

    initial begin
        int rc;
        tbl[0]  = '{OP_ADD, 8'h20, 8'hF0, 8'h10, 1'b0, 1'b1};
        tbl[1]  = '{OP_ADD, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0};
        tbl[2]  = '{OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        tbl[3]  = '{OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
        tbl[4]  = '{OP_SUB, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1};
        tbl[5]  = '{OP_SUB, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
        tbl[6]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        tbl[7]  = '{OP_OR,  8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0};
        tbl[8]  = '{OP_XOR, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0};
        tbl[9]  = '{OP_NOT, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[10] = '{OP_SHL, 8'h81, 8'h00, 8'h02, 1'b0, 1'b1};
        tbl[11] = '{OP_SHR, 8'h81, 8'h00, 8'h40, 1'b0, 1'b1};
        tbl[12] = '{OP_LDR, 8'h77, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[13] = '{OP_NOP, 8'h00, 8'h5A, 8'h00, 1'b1, 1'b0};

        fill(ins(OP_HLT, 2'd0, 8'h00));

        // Reset values while reset is held
        #1 rstn = 1'b0;
        #1;
        chk("rst_acu", 32'(acu_dbg), 0);
        chk("rst_pc", 32'(pc_dbg), 0);
        chk("rst_z", 32'(flag_z), 0);
        chk("rst_cy", 32'(flag_cy), 0);
        chk("rst_retire", 32'(retire), 0);
        chk("rst_halted", 32'(halted), 0);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();

        // Reset asserted mid-EXEC clears everything at once
        mem[0] = ins(OP_LDI, 2'd0, 8'h5A);
        mem[1] = ins(OP_STR, 2'd3, 8'h00);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_acu", 32'(acu_dbg), 32'h5A);
        @(negedge clk);
        chk("pre_rst_retire", 32'(retire), 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_acu", 32'(acu_dbg), 0);
        chk("mid_rst_pc", 32'(pc_dbg), 0);
        chk("mid_rst_z", 32'(flag_z), 0);
        chk("mid_rst_cy", 32'(flag_cy), 0);
        chk("mid_rst_retire", 32'(retire), 0);
        chk("mid_rst_halted", 32'(halted), 0);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        rc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (retire) rc++;
            chk("idle_pc", 32'(pc_dbg), 0);
        end
        chk("idle_retires", 32'(rc), 0);
        // R3 must read back as 0 after the aborted STR
        fill(ins(OP_HLT, 2'd0, 8'h00));
        mem[0] = ins(OP_LDI, 2'd0, 8'h11);
        mem[1] = ins(OP_LDR, 2'd3, 8'h00);
        run(4, 0);
        chk("abort_no_write", 32'(acu_dbg), 0);

        // Single-operation vectors
        for (int t = 0; t < NV; t++) begin
            do_reset();
            fill(ins(OP_HLT, 2'd0, 8'h00));
            mem[0] = ins(OP_LDI, 2'd0, tbl[t].r);
            mem[1] = ins(OP_STR, 2'd1, 8'h00);
            mem[2] = ins(OP_LDI, 2'd0, tbl[t].a);
            mem[3] = ins(tbl[t].op, 2'd1, 8'h00);
            run(8, 0);
            chk($sformatf("vec%0d_acu", t), 32'(acu_dbg), int'(tbl[t].e_acu));
            chk($sformatf("vec%0d_z", t), 32'(flag_z), int'(tbl[t].e_z));
            chk($sformatf("vec%0d_cy", t), 32'(flag_cy), int'(tbl[t].e_cy));
            chk($sformatf("vec%0d_halted", t), 32'(halted), 1);
        end

        // SUB to zero, then SUB with borrow
        do_reset();
        fill(ins(OP_HLT, 2'd0, 8'h00));
        mem[0] = ins(OP_LDI, 2'd0, 8'h05);
        mem[1] = ins(OP_STR, 2'd2, 8'h00);
        mem[2] = ins(OP_SUB, 2'd2, 8'h00);
        mem[3] = ins(OP_LDI, 2'd0, 8'h03);
        mem[4] = ins(OP_SUB, 2'd2, 8'h00);
        run(8, 0);
        chk("subseq_acu", 32'(acu_dbg), 32'hFE);
        chk("subseq_cy", 32'(flag_cy), 1);
        chk("subseq_z", 32'(flag_z), 0);

        // Shift chain
        do_reset();
        fill(ins(OP_HLT, 2'd0, 8'h00));
        mem[0] = ins(OP_LDI, 2'd0, 8'h81);
        mem[1] = ins(OP_SHL, 2'd0, 8'h00);
        mem[2] = ins(OP_SHR, 2'd0, 8'h00);
        run(6, 0);
        chk("shift_acu", 32'(acu_dbg), 32'h01);
        chk("shift_cy", 32'(flag_cy), 0);

        // STR then LDR of the same register
        do_reset();
        fill(ins(OP_HLT, 2'd0, 8'h00));
        mem[0] = ins(OP_LDI, 2'd0, 8'h3C);
        mem[1] = ins(OP_STR, 2'd2, 8'h00);
        mem[2] = ins(OP_LDI, 2'd0, 8'h00);
        mem[3] = ins(OP_LDR, 2'd2, 8'h00);
        run(6, 0);
        chk("str_ldr_acu", 32'(acu_dbg), 32'h3C);

        // Terminating countdown loop
        do_reset();
        fill(ins(OP_HLT, 2'd0, 8'h00));
        mem[0] = ins(OP_LDI, 2'd0, 8'h01);
        mem[1] = ins(OP_STR, 2'd1, 8'h00);
        mem[2] = ins(OP_LDI, 2'd0, 8'h03);
        mem[3] = ins(OP_SUB, 2'd1, 8'h00);
        mem[4] = ins(OP_JZ,  2'd0, 8'h06);
        mem[5] = ins(OP_JMP, 2'd0, 8'h03);
        run(20, 0);
        chk("count_halted", 32'(halted), 1);
        chk("count_pc", 32'(pc_dbg), 6);
`ifdef ACC_CORE_BRANCH_EN
        chk("count_acu", 32'(acu_dbg), 0);
        chk("count_z", 32'(flag_z), 1);
`else
        chk("count_acu", 32'(acu_dbg), 2);
        chk("count_z", 32'(flag_z), 0);
`endif

        // Loop that reloads its counter each pass; only ends when branches are NOPs
        do_reset();
        fill(ins(OP_HLT, 2'd0, 8'h00));
        mem[0] = ins(OP_LDI, 2'd0, 8'h03);
        mem[1] = ins(OP_STR, 2'd0, 8'h00);
        mem[2] = ins(OP_LDI, 2'd0, 8'h01);
        mem[3] = ins(OP_SUB, 2'd0, 8'h00);
        mem[4] = ins(OP_JZ,  2'd0, 8'h06);
        mem[5] = ins(OP_JMP, 2'd0, 8'h02);
        run(24, 0);
        chk("reload_acu", 32'(acu_dbg), 32'hFE);
        chk("reload_cy", 32'(flag_cy), 1);
`ifdef ACC_CORE_BRANCH_EN
        chk("reload_halted", 32'(halted), 0);
`else
        chk("reload_halted", 32'(halted), 1);
`endif

        // pc wraps from 31 to 0
        do_reset();
        fill(ins(OP_NOP, 2'd0, 8'h00));
        run(31, 0);
        chk("wrap_pc31", 32'(pc_dbg), 31);
        @(negedge clk);
        @(negedge clk);
        chk("wrap_pc0", 32'(pc_dbg), 0);

        // Restart from HALT keeps ACU
        do_reset();
        fill(ins(OP_HLT, 2'd0, 8'h00));
        mem[0] = ins(OP_LDI, 2'd0, 8'h55);
        run(4, 0);
        chk("restart_halt1", 32'(halted), 1);
        mem[0] = ins(OP_HLT, 2'd0, 8'h00);
        run(4, 0);
        chk("restart_acu", 32'(acu_dbg), 32'h55);
        chk("restart_pc", 32'(pc_dbg), 0);

        // Random programs with start toggling while running
        for (int s = 0; s < 20; s++) begin
            do_reset();
            for (int k = 0; k < MEMSZ; k++) mem[k] = IW'($urandom);
            run(40, 1);
            if (m_halted != 0) run(20, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
